// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared encodings for the multi-cycle RV32I control sequencer
package ctrl_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC_R,
      S_EXEC_I,
      S_MEM_ADDR,
      S_MEM_RD,
      S_MEM_WR,
      S_WB_ALU,
      S_WB_MEM,
      S_BRANCH,
      S_TRAP
   } state_t;

   localparam logic [1:0] ALU_ADD    = 2'b00;
   localparam logic [1:0] ALU_SUB    = 2'b01;
   localparam logic [1:0] ALU_RFUNCT = 2'b10;
   localparam logic [1:0] ALU_IFUNCT = 2'b11;

   localparam logic [1:0] CAUSE_NONE    = 2'b00;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
   localparam logic [1:0] CAUSE_BUS     = 2'b10;

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - wait-cycle counter shared by the fetch and data-memory wait states
module mem_wait_timer #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic count_en,
   input  logic ready,
   output logic timeout
);

   localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT);

   logic [7:0] count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= 8'd0;
      end else if (clear) begin
         count <= 8'd0;
      end else if (count_en && !ready) begin
         count <= count + 8'd1;
      end
   end

   // ready arriving on the limit cycle masks the timeout
   assign timeout = count_en && !ready && (count == LIMIT);

endmodule

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multi-cycle RV32I control sequencer with instret counter and trap report
module multicycle_control_fsm
   import ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   input  logic [6:0]       opcode,
   input  logic [2:0]       funct3,
   input  logic             zero,
   input  logic             imem_ready,
   input  logic             dmem_ready,
   output logic             ir_write,
   output logic             pc_write,
   output logic             pc_src,
   output logic             reg_write,
   output logic             alu_src,
   output logic [1:0]       alu_op,
   output logic             mem_read,
   output logic             mem_write,
   output logic [1:0]       mem_size,
   output logic             mem_to_reg,
   output logic [CNT_W-1:0] instret,
   output logic             trap,
   output logic [1:0]       trap_cause
);

   state_t     state;
   state_t     state_next;
   logic [1:0] cause_next;
   logic       wait_ready;
   logic       count_en;
   logic       timeout;

   assign wait_ready = (state == S_FETCH) ? imem_ready : dmem_ready;
   assign count_en   = ((state == S_FETCH) && run) || (state == S_MEM_RD) || (state == S_MEM_WR);

   mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .clear    (state_next != state),
      .count_en (count_en),
      .ready    (wait_ready),
      .timeout  (timeout)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_FETCH;
         trap_cause <= CAUSE_NONE;
         instret    <= '0;
      end else begin
         state      <= state_next;
         trap_cause <= cause_next;
         if (pc_write) instret <= instret + CNT_W'(1);
      end
   end

   always_comb begin
      state_next = state;
      cause_next = trap_cause;
      unique case (state)
         S_FETCH: begin
            if (run) begin
               if (imem_ready) begin
                  state_next = S_DECODE;
               end else if (timeout) begin
                  state_next = S_TRAP;
                  cause_next = CAUSE_BUS;
               end
            end
         end
         S_DECODE: begin
            state_next = S_TRAP;
            cause_next = CAUSE_ILLEGAL;
            case (opcode)
               OP_R: begin
                  state_next = S_EXEC_R;
                  cause_next = trap_cause;
               end
               OP_I: begin
                  state_next = S_EXEC_I;
                  cause_next = trap_cause;
               end
               OP_LOAD, OP_STORE: begin
                  if (funct3[1:0] != 2'b11) begin
                     state_next = S_MEM_ADDR;
                     cause_next = trap_cause;
                  end
               end
               OP_BRANCH: begin
                  if (funct3[2:1] == 2'b00) begin
                     state_next = S_BRANCH;
                     cause_next = trap_cause;
                  end
               end
               default: ;
            endcase
         end
         S_EXEC_R, S_EXEC_I: state_next = S_WB_ALU;
         S_MEM_ADDR: state_next = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD, S_MEM_WR: begin
            if (dmem_ready) begin
               state_next = (state == S_MEM_RD) ? S_WB_MEM : S_FETCH;
            end else if (timeout) begin
               state_next = S_TRAP;
               cause_next = CAUSE_BUS;
            end
         end
         S_WB_ALU, S_WB_MEM, S_BRANCH: state_next = S_FETCH;
         S_TRAP: state_next = S_TRAP;
         default: state_next = S_FETCH;
      endcase
   end

   // strobes are forced low for as long as reset is held so nothing partial escapes
   always_comb begin
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      reg_write  = 1'b0;
      alu_src    = 1'b0;
      alu_op     = ALU_ADD;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_size   = 2'b00;
      mem_to_reg = 1'b0;
      if (!reset) begin
         case (state)
            S_FETCH:  ir_write = run && imem_ready;
            S_EXEC_R: alu_op = ALU_RFUNCT;
            S_EXEC_I: begin
               alu_src = 1'b1;
               alu_op  = ALU_IFUNCT;
            end
            S_MEM_ADDR: alu_src = 1'b1;
            S_MEM_RD: begin
               alu_src  = 1'b1;
               mem_read = 1'b1;
               mem_size = funct3[1:0];
            end
            S_MEM_WR: begin
               mem_write = 1'b1;
               mem_size  = funct3[1:0];
               pc_write  = dmem_ready;
            end
            S_WB_ALU: begin
               reg_write = 1'b1;
               pc_write  = 1'b1;
            end
            S_WB_MEM: begin
               reg_write  = 1'b1;
               mem_to_reg = 1'b1;
               pc_write   = 1'b1;
            end
            S_BRANCH: begin
               alu_op   = ALU_SUB;
               pc_write = 1'b1;
               pc_src   = funct3[0] ? ~zero : zero;
            end
            default: ;
         endcase
      end
   end

   assign trap = (state == S_TRAP);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - directed self-checking bench for the multi-cycle control sequencer
module tb_multicycle_control_fsm;

   logic        clk = 1'b0;
   logic        reset;
   logic        run;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic        zero;
   logic        imem_ready;
   logic        dmem_ready;
   logic        ir_write;
   logic        pc_write;
   logic        pc_src;
   logic        reg_write;
   logic        alu_src;
   logic [1:0]  alu_op;
   logic        mem_read;
   logic        mem_write;
   logic [1:0]  mem_size;
   logic        mem_to_reg;
   logic [31:0] instret;
   logic        trap;
   logic [1:0]  trap_cause;

   int n_assert = 0;
   int n_fail   = 0;

   // {ir_write, pc_write, pc_src, reg_write, alu_src, alu_op, mem_read, mem_write, mem_size, mem_to_reg}
   localparam logic [11:0] V_NONE   = 12'h000;
   localparam logic [11:0] V_FETCH  = 12'h800;
   localparam logic [11:0] V_EXEC_R = 12'h040;
   localparam logic [11:0] V_EXEC_I = 12'h0E0;
   localparam logic [11:0] V_WB_ALU = 12'h500;
   localparam logic [11:0] V_MADDR  = 12'h080;
   localparam logic [11:0] V_MRD_W  = 12'h094;
   localparam logic [11:0] V_WB_MEM = 12'h501;
   localparam logic [11:0] V_MWR_W  = 12'h00C;
   localparam logic [11:0] V_MWR_D  = 12'h40C;
   localparam logic [11:0] V_MWR_B  = 12'h008;
   localparam logic [11:0] V_BR_T   = 12'h620;
   localparam logic [11:0] V_BR_N   = 12'h420;

   logic [11:0] strobes;
   assign strobes = {ir_write, pc_write, pc_src, reg_write, alu_src, alu_op,
                     mem_read, mem_write, mem_size, mem_to_reg};

   multicycle_control_fsm #(.MEM_TIMEOUT(15), .CNT_W(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .run        (run),
      .opcode     (opcode),
      .funct3     (funct3),
      .zero       (zero),
      .imem_ready (imem_ready),
      .dmem_ready (dmem_ready),
      .ir_write   (ir_write),
      .pc_write   (pc_write),
      .pc_src     (pc_src),
      .reg_write  (reg_write),
      .alu_src    (alu_src),
      .alu_op     (alu_op),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_size   (mem_size),
      .mem_to_reg (mem_to_reg),
      .instret    (instret),
      .trap       (trap),
      .trap_cause (trap_cause)
   );

   always #5 clk = ~clk;

   task automatic chk_s(input string tag, input logic [11:0] exp);
      n_assert++;
      assert (strobes === exp) else begin
         n_fail++;
         $error("FAIL %s: strobes observed %h expected %h", tag, strobes, exp);
      end
   endtask

   task automatic chk_v(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // settle, check this cycle's strobes, then advance one clock
   task automatic cyc(input string tag, input logic [11:0] exp);
      #1;
      chk_s(tag, exp);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc("reset_held", V_NONE);
      chk_v("reset_instret", instret, 32'd0);
      chk_v("reset_trap", {31'd0, trap}, 32'd0);
      chk_v("reset_cause", {30'd0, trap_cause}, 32'd0);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; run = 1'b1; opcode = 7'd0; funct3 = 3'd0; zero = 1'b0;
      imem_ready = 1'b1; dmem_ready = 1'b1;
      @(posedge clk);
      #1;
      do_reset();

      // R-type
      opcode = 7'b0110011;
      cyc("r_fetch", V_FETCH);
      cyc("r_decode", V_NONE);
      cyc("r_exec", V_EXEC_R);
      chk_v("r_instret_before", instret, 32'd0);
      cyc("r_wb", V_WB_ALU);
      chk_v("r_instret", instret, 32'd1);

      // load word, data ready three cycles late
      opcode = 7'b0000011; funct3 = 3'b010; dmem_ready = 1'b0;
      cyc("ld_fetch", V_FETCH);
      cyc("ld_decode", V_NONE);
      cyc("ld_addr", V_MADDR);
      repeat (3) cyc("ld_wait", V_MRD_W);
      dmem_ready = 1'b1;
      cyc("ld_ready", V_MRD_W);
      cyc("ld_wb", V_WB_MEM);
      chk_v("ld_instret", instret, 32'd2);

      // BEQ taken
      opcode = 7'b1100011; funct3 = 3'b000; zero = 1'b1;
      cyc("beq_fetch", V_FETCH);
      cyc("beq_decode", V_NONE);
      cyc("beq_branch", V_BR_T);
      chk_v("beq_instret", instret, 32'd3);

      // BNE with zero=1, then zero dropped within the same cycle
      funct3 = 3'b001;
      cyc("bne_fetch", V_FETCH);
      cyc("bne_decode", V_NONE);
      #1;
      chk_s("bne_zero1", V_BR_N);
      zero = 1'b0;
      cyc("bne_zero0", V_BR_T);
      chk_v("bne_instret", instret, 32'd4);

      // I-type
      opcode = 7'b0010011; funct3 = 3'b000;
      cyc("i_fetch", V_FETCH);
      cyc("i_decode", V_NONE);
      cyc("i_exec", V_EXEC_I);
      cyc("i_wb", V_WB_ALU);
      chk_v("i_instret", instret, 32'd5);

      // store, ready arrives exactly on the limit cycle
      opcode = 7'b0100011; funct3 = 3'b010; dmem_ready = 1'b0;
      cyc("st_fetch", V_FETCH);
      cyc("st_decode", V_NONE);
      cyc("st_addr", V_MADDR);
      for (int k = 0; k < 15; k++) cyc("st_wait", V_MWR_W);
      dmem_ready = 1'b1;
      cyc("st_edge_done", V_MWR_D);
      chk_v("st_edge_instret", instret, 32'd6);
      chk_v("st_edge_trap", {31'd0, trap}, 32'd0);

      // store, ready stuck low -> bus timeout
      dmem_ready = 1'b0;
      cyc("sto_fetch", V_FETCH);
      cyc("sto_decode", V_NONE);
      cyc("sto_addr", V_MADDR);
      for (int k = 0; k < 16; k++) cyc("sto_wait", V_MWR_W);
      chk_v("sto_trap", {31'd0, trap}, 32'd1);
      chk_v("sto_cause", {30'd0, trap_cause}, 32'd2);
      chk_v("sto_instret", instret, 32'd6);
      dmem_ready = 1'b1;
      cyc("sto_trap_quiet", V_NONE);
      do_reset();

      // illegal opcode
      opcode = 7'b1111111;
      cyc("ill_fetch", V_FETCH);
      cyc("ill_decode", V_NONE);
      chk_v("ill_trap", {31'd0, trap}, 32'd1);
      chk_v("ill_cause", {30'd0, trap_cause}, 32'd1);
      chk_v("ill_instret", instret, 32'd0);
      repeat (20) cyc("ill_quiet", V_NONE);
      chk_v("ill_sticky", {31'd0, trap}, 32'd1);
      do_reset();

      // load with funct3[1:0]=11 is illegal
      opcode = 7'b0000011; funct3 = 3'b011;
      cyc("ldbad_fetch", V_FETCH);
      cyc("ldbad_decode", V_NONE);
      chk_v("ldbad_cause", {30'd0, trap_cause}, 32'd1);
      do_reset();

      // fetch timeout
      imem_ready = 1'b0;
      for (int k = 0; k < 16; k++) cyc("ft_wait", V_NONE);
      chk_v("ft_trap", {31'd0, trap}, 32'd1);
      chk_v("ft_cause", {30'd0, trap_cause}, 32'd2);
      imem_ready = 1'b1;
      do_reset();

      // reset in the middle of a store write
      opcode = 7'b0100011; funct3 = 3'b000; dmem_ready = 1'b0;
      cyc("ab_fetch", V_FETCH);
      cyc("ab_decode", V_NONE);
      cyc("ab_addr", V_MADDR);
      cyc("ab_wr", V_MWR_B);
      reset = 1'b1;
      cyc("ab_abort", V_NONE);
      chk_v("ab_instret", instret, 32'd0);
      reset = 1'b0;

      // run low: no fetch and no timeout counting
      run = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b1;
      repeat (20) cyc("idle", V_NONE);
      chk_v("idle_trap", {31'd0, trap}, 32'd0);
      imem_ready = 1'b1;
      cyc("idle_ready", V_NONE);
      run = 1'b1; opcode = 7'b0110011;
      cyc("run_fetch", V_FETCH);
      cyc("run_decode", V_NONE);
      cyc("run_exec", V_EXEC_R);
      cyc("run_wb", V_WB_ALU);
      chk_v("run_instret", instret, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
